// File: rtl/alu_pipe_if.sv
// Request/response bundle between the operand sequencer and the pipelined ALU.
// master = sequencer/writeback side, slave = the ALU.
interface alu_pipe_if #(
    parameter int n     = 8,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [n-1:0]     in_a;
    logic [n-1:0]     in_b;
    logic [3:0]       in_opcode;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [n-1:0]     out_result;
    logic [3:0]       out_flags;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;

    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_opcode, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_err, out_tag, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_opcode, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_err, out_tag, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 holds the operation (and runs the iterative multiply),
// the output register holds the result, flags, error bit and tag until consumed.
module alu_pipe #(
    parameter int n     = 8,
    parameter int TAG_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_pipe_if.slave  bus
);
    localparam int SH_W = $clog2(n);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_SLT = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // S1 stage
    logic             s1_valid_q;
    logic [n-1:0]     s1_a_q;
    logic [n-1:0]     s1_b_q;
    logic [3:0]       s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;

    // Multiplier
    mul_state_t       state_q, state_d;
    logic [2*n-1:0]   acc_q, acc_d;
    logic [SH_W-1:0]  cnt_q, cnt_d;
    logic [2*n-1:0]   mul_partial;

    // Output register
    logic             out_valid_q;
    logic [n-1:0]     out_result_q;
    logic [3:0]       out_flags_q;
    logic             out_err_q;
    logic [TAG_W-1:0] out_tag_q;

    // Handshake
    logic out_free;
    logic s1_result_ready;
    logic s1_advance;
    logic in_ready;
    logic in_fire;
    logic in_is_mul;

    assign out_free        = !out_valid_q || bus.out_ready;
    assign s1_result_ready = (s1_op_q != OP_MUL) || (state_q == DONE);
    assign s1_advance      = s1_valid_q && s1_result_ready && out_free;
    assign in_ready        = !s1_valid_q || s1_advance;
    assign in_fire         = bus.in_valid && in_ready;
    assign in_is_mul       = (bus.in_opcode == OP_MUL);

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_flags  = out_flags_q;
    assign bus.out_err    = out_err_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.busy       = (state_q == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s1_tag_q   <= '0;
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
            s1_a_q     <= bus.in_a;
            s1_b_q     <= bus.in_b;
            s1_op_q    <= bus.in_opcode;
            s1_tag_q   <= bus.in_tag;
        end else if (s1_advance) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Shift-add multiply, LSB of b first; the partial is a shifted by the bit index.
    assign mul_partial = s1_b_q[cnt_q] ? ({{n{1'b0}}, s1_a_q} << cnt_q) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_fire && in_is_mul) begin
                    state_d = RUN;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                acc_d = acc_q + mul_partial;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SH_W'(n - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A following op may load S1 on the same edge the product retires.
                if (s1_advance) begin
                    if (in_fire && in_is_mul) begin
                        state_d = RUN;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Execute
    logic [SH_W-1:0] sh;
    logic [n:0]      sum_ext;
    logic [n:0]      diff_ext;
    logic [n:0]      shl_ext;
    logic [n:0]      shr_ext;
    logic [n:0]      sra_ext;
    logic            slt_bit;
    logic [n-1:0]    ex_result;
    logic            ex_c;
    logic            ex_v;
    logic            ex_err;
    logic [3:0]      ex_flags;

    assign sh       = s1_b_q[SH_W-1:0];
    assign sum_ext  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign diff_ext = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    // Right shifts keep one guard bit below the LSB so it captures the last bit shifted out.
    assign shl_ext  = {1'b0, s1_a_q} << sh;
    assign shr_ext  = {s1_a_q, 1'b0} >> sh;
    assign sra_ext  = $unsigned($signed({s1_a_q, 1'b0}) >>> sh);
    assign slt_bit  = $signed(s1_a_q) < $signed(s1_b_q);

    always_comb begin
        ex_result = '0;
        ex_c      = 1'b0;
        ex_v      = 1'b0;
        ex_err    = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                ex_result = sum_ext[n-1:0];
                ex_c      = sum_ext[n];
                ex_v      = (s1_a_q[n-1] == s1_b_q[n-1]) && (sum_ext[n-1] != s1_a_q[n-1]);
            end
            OP_SUB: begin
                ex_result = diff_ext[n-1:0];
                ex_c      = diff_ext[n];
                ex_v      = (s1_a_q[n-1] != s1_b_q[n-1]) && (diff_ext[n-1] != s1_a_q[n-1]);
            end
            OP_AND: ex_result = s1_a_q & s1_b_q;
            OP_OR:  ex_result = s1_a_q | s1_b_q;
            OP_XOR: ex_result = s1_a_q ^ s1_b_q;
            OP_NOT: ex_result = ~s1_a_q;
            OP_SHL: begin
                ex_result = shl_ext[n-1:0];
                ex_c      = shl_ext[n];
            end
            OP_SHR: begin
                ex_result = shr_ext[n:1];
                ex_c      = shr_ext[0];
            end
            OP_SRA: begin
                ex_result = sra_ext[n:1];
                ex_c      = sra_ext[0];
            end
            OP_SLT: ex_result = {{(n-1){1'b0}}, slt_bit};
            OP_MUL: begin
                ex_result = acc_q[n-1:0];
                ex_c      = |acc_q[2*n-1:n];
            end
            default: ex_err = 1'b1;
        endcase
    end

    assign ex_flags = {ex_c, ex_v, (ex_result == '0), ex_result[n-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            out_err_q    <= 1'b0;
            out_tag_q    <= '0;
        end else if (s1_advance) begin
            out_valid_q  <= 1'b1;
            out_result_q <= ex_result;
            out_flags_q  <= ex_flags;
            out_err_q    <= ex_err;
            out_tag_q    <= s1_tag_q;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed checks of alu_pipe against an arithmetic reference model
// with an in-order scoreboard of expected results.
module tb_alu_pipe;
    localparam int N      = 8;
    localparam int TW     = 4;
    localparam int BUDGET = 200;

    typedef struct packed {
        logic [N-1:0]  res;
        logic [3:0]    flags;
        logic          err;
        logic [TW-1:0] tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    alu_pipe_if #(.n(N), .TAG_W(TW)) bus ();

    alu_pipe #(.n(N), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t ref_model(input logic [3:0] op, input logic [N-1:0] a,
                                       input logic [N-1:0] b, input logic [TW-1:0] tag);
        exp_t   e;
        longint m, smax, smin, ua, ub, sa, sb, r, p;
        int     sh;
        bit     c, v, err;
        m    = (longint'(1) << N) - 1;
        smax = (longint'(1) << (N - 1)) - 1;
        smin = -(longint'(1) << (N - 1));
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = a[N-1] ? ua - (m + 1) : ua;
        sb   = b[N-1] ? ub - (m + 1) : ub;
        sh   = int'(ub % N);
        c = 0; v = 0; err = 0; r = 0;
        case (op)
            4'd0: begin r = (ua + ub) & m; c = (ua + ub) > m;
                        v = (sa + sb > smax) || (sa + sb < smin); end
            4'd1: begin r = (ua - ub) & m; c = ua < ub;
                        v = (sa - sb > smax) || (sa - sb < smin); end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = (~ua) & m;
            4'd6: begin r = (ua << sh) & m; c = (sh != 0) && (((ua >> (N - sh)) & 1) != 0); end
            4'd7: begin r = ua >> sh;       c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0); end
            4'd8: begin r = (sa >>> sh) & m; c = (sh != 0) && (((sa >>> (sh - 1)) & 1) != 0); end
            4'd9: r = (sa < sb) ? 1 : 0;
            4'd10: begin p = ua * ub; r = p & m; c = (p >> N) != 0; end
            default: begin err = 1; r = 0; end
        endcase
        e.res   = r[N-1:0];
        e.flags = {c, v, (r == 0), r[N-1]};
        e.err   = err;
        e.tag   = tag;
        return e;
    endfunction

    // Scoreboard: every cycle with a valid result must show the oldest outstanding op.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(bus.out_valid), 64'(0));
                end else begin
                    check("result", 64'({bus.out_result, bus.out_flags, bus.out_err, bus.out_tag}),
                          64'(exp_q[0]));
                    if (bus.out_ready) begin
                        $display("xfer tag=%0h res=%02h flags=%b err=%b",
                                 bus.out_tag, bus.out_result, bus.out_flags, bus.out_err);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ref_model(bus.in_opcode, bus.in_a, bus.in_b, bus.in_tag));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [TW-1:0] tag);
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = tag;
    endtask

    // Returns just after the accepting edge.
    task automatic wait_accept(input bit rnd);
        bit got;
        got = 0;
        for (int k = 0; k < BUDGET && !got; k++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1;
            next_cycle();
            if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.in_valid = 1'b0;
        if (!got) check("accept_timeout", 64'(0), 64'(1));
    endtask

    // Returns at the negedge where out_valid is first seen.
    task automatic wait_out();
        bit got;
        got = 0;
        for (int k = 0; k < BUDGET && !got; k++) begin
            @(negedge clk);
            if (bus.out_valid) got = 1;
        end
        if (!got) check("out_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_opcode = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) next_cycle();
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_outs", 64'({bus.out_result, bus.out_flags, bus.out_err, bus.out_tag}), 64'(0));
        next_cycle();

        // ADD with carry-out to zero, two-edge latency
        drive(4'd0, 8'hFF, 8'h01, 4'd3);
        wait_accept(0);
        @(negedge clk);
        check("add_lat_early", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        check("add_lat_valid", 64'(bus.out_valid), 64'(1));
        check("add_result", 64'(bus.out_result), 64'(8'h00));
        check("add_flags", 64'(bus.out_flags), 64'(4'b1010));
        check("add_tag_err", 64'({bus.out_tag, bus.out_err}), 64'({4'd3, 1'b0}));
        repeat (2) next_cycle();

        // SUB then SRA back-to-back
        drive(4'd1, 8'h80, 8'h01, 4'd1);
        wait_accept(0);
        drive(4'd8, 8'h90, 8'h03, 4'd2);
        wait_accept(0);
        @(negedge clk);
        check("sub_result", 64'({bus.out_valid, bus.out_result, bus.out_flags}), 64'({1'b1, 8'h7F, 4'b0100}));
        next_cycle();
        @(negedge clk);
        check("sra_result", 64'({bus.out_valid, bus.out_result, bus.out_flags}), 64'({1'b1, 8'hF2, 4'b0001}));
        repeat (2) next_cycle();

        // MUL with high half non-zero
        drive(4'd10, 8'h10, 8'h10, 4'd4);
        wait_accept(0);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check("mul_busy", 64'(bus.busy), 64'(1));
            check("mul_in_ready", 64'(bus.in_ready), 64'(0));
            next_cycle();
        end
        @(negedge clk);
        check("mul_busy_end", 64'({bus.busy, bus.out_valid}), 64'(0));
        next_cycle();
        @(negedge clk);
        check("mul_out", 64'({bus.out_valid, bus.out_result, bus.out_flags}), 64'({1'b1, 8'h00, 4'b1010}));
        repeat (2) next_cycle();

        drive(4'd10, 8'h0F, 8'h03, 4'd5);
        wait_accept(0);
        wait_out();
        check("mul2_out", 64'({bus.out_result, bus.out_flags}), 64'({8'h2D, 4'b0000}));
        repeat (2) next_cycle();

        // Backpressure: two ops absorbed, third blocked
        bus.out_ready = 1'b0;
        drive(4'd0, 8'h10, 8'h20, 4'd5);
        wait_accept(0);
        drive(4'd0, 8'h7F, 8'h01, 4'd6);
        wait_accept(0);
        drive(4'd0, 8'h01, 8'h02, 4'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus.in_ready), 64'(0));
            check("bp_hold_tag", 64'({bus.out_valid, bus.out_tag}), 64'({1'b1, 4'd5}));
            next_cycle();
        end
        bus.out_ready = 1'b1;
        wait_accept(0);
        @(negedge clk);
        check("bp_second", 64'({bus.out_valid, bus.out_tag}), 64'({1'b1, 4'd6}));
        next_cycle();
        @(negedge clk);
        check("bp_third", 64'({bus.out_valid, bus.out_tag}), 64'({1'b1, 4'd7}));
        repeat (2) next_cycle();

        // Illegal opcode, then a legal op clears err
        drive(4'hC, 8'h55, 8'h00, 4'd8);
        wait_accept(0);
        wait_out();
        check("ill_out", 64'({bus.out_result, bus.out_err, bus.out_flags}), 64'({8'h00, 1'b1, 4'b0010}));
        next_cycle();
        drive(4'd0, 8'h01, 8'h02, 4'd9);
        wait_accept(0);
        wait_out();
        check("legal_clears_err", 64'({bus.out_result, bus.out_err}), 64'({8'h03, 1'b0}));
        repeat (2) next_cycle();

        // Reset during MUL RUN
        drive(4'd10, 8'h33, 8'h44, 4'hA);
        wait_accept(0);
        repeat (3) next_cycle();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_busy", 64'(bus.busy), 64'(0));
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
        repeat (2) next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * N + 4; i++) begin
            @(negedge clk);
            check("no_stale_out", 64'(bus.out_valid), 64'(0));
            next_cycle();
        end
        @(negedge clk);
        check("post_rst_ready", 64'({bus.in_ready, bus.busy}), 64'({1'b1, 1'b0}));
        next_cycle();

        // Randomised traffic with random backpressure
        for (int t = 0; t < 400; t++) begin
            logic [3:0] op;
            while ($urandom_range(0, 3) == 0) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                next_cycle();
            end
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(11, 15));
            else                          op = 4'($urandom_range(0, 10));
            drive(op, N'($urandom), N'($urandom), TW'(t));
            wait_accept(1);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < BUDGET && exp_q.size() != 0; k++) next_cycle();
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        repeat (2) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
